// File: rtl/axis_to_vid_out.sv
// AXI4-Stream (tuser = SOF, tlast = EOL) to native parallel video output.
// A free-running timing generator sets the output timing; a lock FSM aligns the stream to it.
module axis_to_vid_out #(
  parameter int         H_ACTIVE  = 720,
  parameter int         H_FP      = 16,
  parameter int         H_SYNC    = 62,
  parameter int         H_BP      = 60,
  parameter int         V_ACTIVE  = 480,
  parameter int         V_FP      = 9,
  parameter int         V_SYNC    = 6,
  parameter int         V_BP      = 30,
  parameter int         SYNC_POL  = 0,
  parameter logic [7:0] BLANK_VAL = 8'h00
) (
  input  logic       aclk,
  input  logic       reset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] vid_data,
  output logic       vid_hsync,
  output logic       vid_vsync,
  output logic       vid_active_video,
  output logic       locked,
  output logic       underflow_err,
  output logic       sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare code so the sync end position is representable even with a zero back porch.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL    = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SYNC_ON  = (SYNC_POL != 0);

  typedef enum logic {WAIT_SOF, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcount_q, hcount_d;
  logic [VW-1:0]   vcount_q, vcount_d;
  logic            active, hs, vs, at_origin, eol_pos;
  logic            ready_c, take_c, underflow_d, sync_err_d;
  logic [7:0]      vid_data_q;
  logic            hsync_q, vsync_q, active_q, underflow_q, sync_err_q;

  always_comb begin
    hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
  end

  assign active    = (hcount_q < H_ACT) && (vcount_q < V_ACT);
  assign hs        = (hcount_q >= HS_START) && (hcount_q < HS_END);
  assign vs        = (vcount_q >= VS_START) && (vcount_q < VS_END);
  assign at_origin = (hcount_q == '0) && (vcount_q == '0);
  assign eol_pos   = (hcount_q == H_EOL);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    take_c      = 1'b0;
    underflow_d = 1'b0;
    sync_err_d  = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        if (s_axis_tvalid && !s_axis_tuser) begin
          ready_c = 1'b1;
        end else if (s_axis_tvalid && s_axis_tuser && at_origin) begin
          ready_c = 1'b1;
          take_c  = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (active) begin
          ready_c = 1'b1;
          if (!s_axis_tvalid) begin
            underflow_d = 1'b1;
            state_d     = WAIT_SOF;
          end else if (s_axis_tuser && !at_origin) begin
            // Leave the early SOF in the stream so it can start the next frame.
            ready_c    = 1'b0;
            sync_err_d = 1'b1;
            state_d    = WAIT_SOF;
          end else begin
            take_c = 1'b1;
            if (s_axis_tlast != eol_pos) begin
              sync_err_d = 1'b1;
              state_d    = WAIT_SOF;
            end
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= WAIT_SOF;
      hcount_q    <= '0;
      vcount_q    <= '0;
      vid_data_q  <= BLANK_VAL;
      hsync_q     <= ~SYNC_ON;
      vsync_q     <= ~SYNC_ON;
      active_q    <= 1'b0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      vid_data_q  <= take_c ? s_axis_tdata : BLANK_VAL;
      hsync_q     <= hs ? SYNC_ON : ~SYNC_ON;
      vsync_q     <= vs ? SYNC_ON : ~SYNC_ON;
      active_q    <= active;
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Ready is combinational from the counters, so it is forced low while reset is applied.
  assign s_axis_tready    = ready_c && !reset;
  assign vid_data         = vid_data_q;
  assign vid_hsync        = hsync_q;
  assign vid_vsync        = vsync_q;
  assign vid_active_video = active_q;
  assign locked           = (state_q == LOCKED);
  assign underflow_err    = underflow_q;
  assign sync_err         = sync_err_q;

endmodule

// File: tb/tb_axis_to_vid_out.sv
// Directed bench for axis_to_vid_out with a 14x7 raster (8x4 active), SYNC_POL=1, BLANK_VAL=AA.
// A beat queue feeds the stream; bench-side h/v trackers give the position of each output cycle.
module tb_axis_to_vid_out;

  logic       aclk = 1'b0;
  logic       reset;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [7:0] vid_data;
  logic       vid_hsync, vid_vsync, vid_active_video, locked, underflow_err, sync_err;

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } beat_t;

  beat_t q[$];
  int    h, v, ph, pv;
  int    n_checks, n_fail, n_consumed;
  logic  last_ready;

  localparam logic [13:0] RST_VEC = {8'hAA, 6'b000000};

  axis_to_vid_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .BLANK_VAL(8'hAA)
  ) dut (
    .aclk(aclk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .vid_data(vid_data), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
    .vid_active_video(vid_active_video), .locked(locked),
    .underflow_err(underflow_err), .sync_err(sync_err)
  );

  always #5 aclk = ~aclk;

  // Packed view of all registered outputs: {data, hsync, vsync, active, locked, underflow, sync_err}.
  function automatic logic [13:0] out_vec();
    return {vid_data, vid_hsync, vid_vsync, vid_active_video, locked, underflow_err, sync_err};
  endfunction

  // Expected outputs for a position: active 8x4, hsync at h 10..11, vsync on line 5.
  function automatic logic [13:0] expect_out(int eh, int ev, logic lk, logic [7:0] base);
    logic       act;
    logic [7:0] d;
    act = (eh < 8) && (ev < 4);
    d   = (lk && act) ? base + 8'(8 * ev + eh) : 8'hAA;
    return {d, logic'(eh == 10 || eh == 11), logic'(ev == 5), act, lk, 1'b0, 1'b0};
  endfunction

  task automatic drive();
    if (q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      {s_axis_tuser, s_axis_tlast, s_axis_tdata} = q[0];
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = 8'h00;
    end
  endtask

  // One clock: sample handshake mid-cycle, then step the bench position trackers.
  task automatic cycle();
    logic fire, rst_s;
    @(negedge aclk);
    last_ready = s_axis_tready;
    fire       = s_axis_tvalid && s_axis_tready;
    rst_s      = reset;
    @(posedge aclk);
    #1;
    if (fire) begin
      q.delete(0);
      n_consumed++;
    end
    ph = h;
    pv = v;
    if (rst_s) begin
      h = 0;
      v = 0;
    end else if (h == 13) begin
      h = 0;
      v = (v == 6) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
    drive();
  endtask

  task automatic push_frame(logic [7:0] base, int n, int bad_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.user = (i == 0);
      b.last = (i % 8 == 7);
      if (bad_last >= 0 && i == 7) b.last = 1'b0;
      if (i == bad_last) b.last = 1'b1;
      b.data = base + 8'(i);
      q.push_back(b);
    end
  endtask

  task automatic do_reset();
    q.delete();
    reset = 1'b1;
    drive();
    cycle();
    cycle();
    reset = 1'b0;
    n_consumed = 0;
  endtask

  task automatic test_reset();
    logic [13:0] exp_v;
    q.delete();
    q.push_back({1'b0, 1'b0, 8'h55});
    reset = 1'b1;
    drive();
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if (out_vec() !== RST_VEC) begin
        n_fail++;
        $display("FAIL reset_outputs cycle=%0d got %h exp %h", k, out_vec(), RST_VEC);
      end
      n_checks++;
      if (last_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_tready cycle=%0d got %b exp 0", k, last_ready);
      end
    end
    reset = 1'b0;
    n_consumed = 0;
    for (int i = 0; i < 98; i++) begin
      cycle();
      exp_v = expect_out(ph, pv, 1'b0, 8'h00);
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL idle_timing h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
    n_checks++;
    if (n_consumed !== 1) begin
      n_fail++;
      $display("FAIL idle_junk_consumed got %0d exp 1", n_consumed);
    end
  endtask

  task automatic test_continuous();
    logic [13:0] exp_v;
    do_reset();
    push_frame(8'h00, 32, -1);
    push_frame(8'h00, 32, -1);
    drive();
    for (int i = 0; i < 196; i++) begin
      cycle();
      exp_v = expect_out(ph, pv, 1'b1, 8'h00);
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL cont_frame h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
    n_checks++;
    if (n_consumed !== 64) begin
      n_fail++;
      $display("FAIL cont_consumed got %0d exp 64", n_consumed);
    end
  endtask

  task automatic test_junk();
    logic [13:0] exp_v;
    do_reset();
    for (int i = 0; i < 5; i++) q.push_back({1'b0, 1'b0, 8'hF0 + 8'(i)});
    push_frame(8'h00, 32, -1);
    drive();
    for (int i = 0; i < 98; i++) begin
      cycle();
      if (i < 5) begin
        n_checks++;
        if (last_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL junk_tready beat=%0d got %b exp 1", i, last_ready);
        end
      end
      exp_v = expect_out(ph, pv, 1'b0, 8'h00);
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL junk_unlocked h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
    n_checks++;
    if (n_consumed !== 5) begin
      n_fail++;
      $display("FAIL junk_sof_held got %0d exp 5", n_consumed);
    end
    for (int i = 0; i < 98; i++) begin
      cycle();
      exp_v = expect_out(ph, pv, 1'b1, 8'h00);
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL junk_locked h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
    n_checks++;
    if (n_consumed !== 37) begin
      n_fail++;
      $display("FAIL junk_consumed got %0d exp 37", n_consumed);
    end
  endtask

  task automatic test_underflow();
    logic [13:0] exp_v;
    logic        lk;
    do_reset();
    push_frame(8'h00, 13, -1);
    drive();
    lk = 1'b1;
    for (int i = 0; i < 98; i++) begin
      cycle();
      if (ph == 5 && pv == 1) begin
        exp_v = {8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        lk    = 1'b0;
        push_frame(8'h00, 32, -1);
        drive();
      end else begin
        exp_v = expect_out(ph, pv, lk, 8'h00);
      end
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL underflow_frame h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
    for (int i = 0; i < 98; i++) begin
      cycle();
      exp_v = expect_out(ph, pv, 1'b1, 8'h00);
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL underflow_relock h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
  endtask

  task automatic test_tlast();
    logic [13:0] exp_v;
    logic        lk;
    do_reset();
    push_frame(8'h00, 32, 5);
    push_frame(8'h40, 32, -1);
    drive();
    lk = 1'b1;
    for (int i = 0; i < 98; i++) begin
      cycle();
      if (ph == 5 && pv == 0) begin
        exp_v = {8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        lk    = 1'b0;
      end else begin
        exp_v = expect_out(ph, pv, lk, 8'h00);
      end
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL tlast_frame h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
    n_checks++;
    if (n_consumed !== 32) begin
      n_fail++;
      $display("FAIL tlast_discard got %0d exp 32", n_consumed);
    end
    for (int i = 0; i < 98; i++) begin
      cycle();
      exp_v = expect_out(ph, pv, 1'b1, 8'h40);
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL tlast_relock h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] exp_v;
    do_reset();
    push_frame(8'h00, 32, -1);
    push_frame(8'h40, 32, -1);
    drive();
    for (int i = 0; i < 31; i++) begin
      cycle();
      exp_v = expect_out(ph, pv, 1'b1, 8'h00);
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL mid_pre h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++;
    if (out_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got %h exp %h", out_vec(), RST_VEC);
    end
    n_checks++;
    if (last_ready !== 1'b0 || n_consumed !== 19) begin
      n_fail++;
      $display("FAIL mid_reset_stream tready=%b consumed=%0d exp 0/19", last_ready, n_consumed);
    end
    for (int i = 0; i < 98; i++) begin
      cycle();
      exp_v = expect_out(ph, pv, 1'b0, 8'h00);
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL mid_post h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
    n_checks++;
    if (n_consumed !== 32) begin
      n_fail++;
      $display("FAIL mid_discard got %0d exp 32", n_consumed);
    end
    for (int i = 0; i < 98; i++) begin
      cycle();
      exp_v = expect_out(ph, pv, 1'b1, 8'h40);
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL mid_relock h=%0d v=%0d got %h exp %h", ph, pv, out_vec(), exp_v);
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    n_consumed = 0;
    h          = 0;
    v          = 0;
    ph         = 0;
    pv         = 0;
    last_ready = 1'b0;
    reset      = 1'b1;
    test_reset();
    test_continuous();
    test_junk();
    test_underflow();
    test_tlast();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
